// File: rtl/bcd_counter_7seg.sv
// ---------------------------------------------------------------------------
// bcd_counter_7seg
//   Multi-digit decimal (BCD) counter with a built-in prescaler, up/down
//   stepping, parallel load, a one-cycle terminal-count pulse and a
//   per-digit active-low 7-segment decode with optional leading-zero
//   blanking. Everything runs on the rising edge of clk.
//
// Parameters
//   DIGITS   : number of BCD digits (>=1), digit 0 least significant
//   PRESCALE : enabled clk cycles per count step (>=1)
//   BLANK_LZ : 1 = blank leading zero digits (digit 0 is never blanked)
//
// Ports
//   clk      in   system clock
//   clr      in   synchronous active-high reset
//   en       in   count enable (gates prescaler and stepping)
//   up       in   1 = increment, 0 = decrement (sampled at step edges)
//   load     in   synchronous parallel load strobe (ignores en)
//   load_val in   BCD load value, digit i at [4i+3:4i]
//   bcd      out  registered BCD count
//   seg      out  active-low segments, digit i at [7i+6:7i], order g..a
//   tc       out  registered one-cycle terminal-count (wrap) pulse
// ---------------------------------------------------------------------------
module bcd_counter_7seg #(
   parameter int DIGITS   = 2,
   parameter int PRESCALE = 5000000,
   parameter int BLANK_LZ = 0
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   seg,
   output logic                  tc
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PSC_MAX = PW'(PRESCALE - 1);

   logic [PW-1:0]       psc_q, psc_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                tc_q,  tc_d;

   logic [4*DIGITS-1:0] step_val;
   logic                wrap;

   // Digits above 9 are not valid BCD; they load as 0.
   function automatic logic [4*DIGITS-1:0] sanitize(input logic [4*DIGITS-1:0] v);
      logic [4*DIGITS-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
      end
      return r;
   endfunction

   // Active-low 7-segment code, bit order g,f,e,d,c,b,a.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Value after one step: ripple carry/borrow through all digits in the
   // same cycle. A carry/borrow out of the top digit means the counter wrapped.
   always_comb begin : step_calc
      logic       carry;
      logic [3:0] dig;
      step_val = bcd_q;
      carry    = 1'b1;
      dig      = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         dig = bcd_q[4*i +: 4];
         if (carry) begin
            if (up) begin
               if (dig >= 4'd9) begin
                  step_val[4*i +: 4] = 4'd0;
               end else begin
                  step_val[4*i +: 4] = dig + 4'd1;
                  carry = 1'b0;
               end
            end else begin
               if (dig == 4'd0) begin
                  step_val[4*i +: 4] = 4'd9;
               end else begin
                  step_val[4*i +: 4] = dig - 4'd1;
                  carry = 1'b0;
               end
            end
         end
      end
      wrap = carry;
   end

   // Next-state: load beats stepping; load and an expiring prescale both
   // restart the prescaler so a partial count is discarded.
   always_comb begin
      psc_d = psc_q;
      bcd_d = bcd_q;
      tc_d  = 1'b0;
      if (load) begin
         bcd_d = sanitize(load_val);
         psc_d = '0;
      end else if (en) begin
         if (psc_q == PSC_MAX) begin
            psc_d = '0;
            bcd_d = step_val;
            tc_d  = wrap;
         end else begin
            psc_d = psc_q + PW'(1);
         end
      end
   end

   // Registered state
   always_ff @(posedge clk) begin
      if (clr) begin
         psc_q <= '0;
         bcd_q <= '0;
         tc_q  <= 1'b0;
      end else begin
         psc_q <= psc_d;
         bcd_q <= bcd_d;
         tc_q  <= tc_d;
      end
   end

   // Display decode straight off the registered count (no added latency).
   // Scanning from the top digit down, a digit stays blank while it and every
   // digit above it are zero.
   always_comb begin : seg_decode
      logic lead;
      lead = 1'b1;
      seg  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         seg[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
      end
      if (BLANK_LZ != 0) begin
         for (int i = DIGITS - 1; i >= 1; i--) begin
            lead = lead && (bcd_q[4*i +: 4] == 4'd0);
            if (lead) seg[7*i +: 7] = 7'b1111111;
         end
      end
   end

   assign bcd = bcd_q;
   assign tc  = tc_q;

endmodule

// File: tb/tb_bcd_counter_7seg.sv
module tb_bcd_counter_7seg;

   logic        clk = 1'b0;
   logic        clr, en, up, load;
   logic [7:0]  load_val;
   logic [7:0]  bcd,  bcd1;
   logic [13:0] seg,  seg1;
   logic        tc,   tc1;

   int checks = 0;
   int errors = 0;
   logic tc_seen;

   always #5 clk = ~clk;

   bcd_counter_7seg #(.DIGITS(2), .PRESCALE(4), .BLANK_LZ(0)) dut (
      .clk(clk), .clr(clr), .en(en), .up(up), .load(load),
      .load_val(load_val), .bcd(bcd), .seg(seg), .tc(tc));

   bcd_counter_7seg #(.DIGITS(2), .PRESCALE(4), .BLANK_LZ(1)) dut_blank (
      .clk(clk), .clr(clr), .en(en), .up(up), .load(load),
      .load_val(load_val), .bcd(bcd1), .seg(seg1), .tc(tc1));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit
   // after the rising edge.
   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      clr = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
      tick();
      clr = 1'b0;
      // 1. reset
      check("rst_bcd", bcd, 8'h00);
      check("rst_seg", seg, 14'b1000000_1000000);
      check("rst_tc", tc, 1'b0);
      check("rst_seg_blank", seg1, 14'b1111111_1000000);
      tick(5);
      check("rst_hold_bcd", bcd, 8'h00);
      check("rst_hold_tc", tc, 1'b0);

      // 2. up count
      en = 1'b1; up = 1'b1; tc_seen = 1'b0;
      tick(3);
      check("up_pre_step", bcd, 8'h00);
      tick();
      check("up_first_step", bcd, 8'h01);
      for (int k = 0; k < 36; k++) begin
         tc_seen = tc_seen | tc;
         tick();
      end
      tc_seen = tc_seen | tc;
      check("up40_bcd", bcd, 8'h10);
      check("up40_seg_hi", seg[13:7], 7'b1111001);
      check("up40_seg_lo", seg[6:0], 7'b1000000);
      check("up40_no_tc", tc_seen, 1'b0);
      check("up40_blank_seg", seg1, 14'b1111001_1000000);

      // 3. up wrap
      en = 1'b0; load = 1'b1; load_val = 8'h99;
      tick();
      load = 1'b0;
      check("load99", bcd, 8'h99);
      check("load99_tc", tc, 1'b0);
      check("load99_seg", seg, 14'b0010000_0010000);
      en = 1'b1;
      tick(3);
      check("wrap_pre", bcd, 8'h99);
      tick();
      check("wrap_bcd", bcd, 8'h00);
      check("wrap_tc", tc, 1'b1);
      check("wrap_tc_blank", tc1, 1'b1);
      tick();
      check("wrap_tc_low", tc, 1'b0);
      tick(3);
      check("wrap_next_bcd", bcd, 8'h01);
      check("wrap_next_tc", tc, 1'b0);

      // 4. down / borrow
      en = 1'b0; load = 1'b1; load_val = 8'h10; up = 1'b0;
      tick();
      load = 1'b0; en = 1'b1;
      tick(4);
      check("borrow_bcd", bcd, 8'h09);
      check("borrow_tc", tc, 1'b0);
      en = 1'b0; load = 1'b1; load_val = 8'h00;
      tick();
      load = 1'b0; en = 1'b1;
      tick(4);
      check("down_wrap_bcd", bcd, 8'h99);
      check("down_wrap_tc", tc, 1'b1);
      tick();
      check("down_wrap_tc_low", tc, 1'b0);

      // 5. priority / invalid digits
      en = 1'b0; up = 1'b1; load = 1'b1; load_val = 8'hA5;
      tick();
      load = 1'b0;
      check("load_invalid", bcd, 8'h05);
      check("load_invalid_blank_bcd", bcd1, 8'h05);
      check("blank_05_seg", seg1, 14'b1111111_0010010);
      check("noblank_05_seg", seg, 14'b1000000_0010010);
      clr = 1'b1; load = 1'b1; load_val = 8'h42;
      tick();
      clr = 1'b0; load = 1'b0;
      check("clr_over_load", bcd, 8'h00);
      check("blank_00_seg", seg1, 14'b1111111_1000000);
      en = 1'b1;
      tick(2);
      load = 1'b1; load_val = 8'h20;
      tick();
      load = 1'b0;
      check("midload_bcd", bcd, 8'h20);
      tick(3);
      check("midload_pre_step", bcd, 8'h20);
      tick();
      check("midload_step", bcd, 8'h21);

      // 6. hold with en low mid-prescale
      tick(2);
      en = 1'b0;
      tick(10);
      check("hold_bcd", bcd, 8'h21);
      en = 1'b1;
      tick();
      check("hold_resume1", bcd, 8'h21);
      tick();
      check("hold_resume2", bcd, 8'h22);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
